// File: rtl/mux_cfg_chain_writer_if.sv
// Handshake/bus bundle between the configuration chain and one mux select writer.
// The slave modport is the writer's view; master is the upstream/bench view.
interface mux_cfg_chain_writer_if #(
  parameter int NUM_MEM = 4
);
  logic                 ccff_head;
  logic                 ccff_head_valid;
  logic                 ccff_head_ready;
  logic                 ccff_tail;
  logic                 ccff_tail_valid;
  logic                 commit;
  logic                 commit_done;
  logic                 cfg_error;
  logic                 busy;
  logic [0:NUM_MEM-1]   mem;
  logic [0:NUM_MEM-1]   mem_inv;

  modport slave (
    input  ccff_head, ccff_head_valid, commit,
    output ccff_head_ready, ccff_tail, ccff_tail_valid,
    output commit_done, cfg_error, busy, mem, mem_inv
  );

  modport master (
    output ccff_head, ccff_head_valid, commit,
    input  ccff_head_ready, ccff_tail, ccff_tail_valid,
    input  commit_done, cfg_error, busy, mem, mem_inv
  );
endinterface

// File: rtl/mux_cfg_chain_writer.sv
// Serial config-chain segment that loads a TGATE select word and applies it
// break-before-make, so no two TGATEs sharing an output ever conduct together.
//
// state | meaning
// IDLE  | accepting chain bits; a commit request starts the apply sequence
// CHECK | validating bit count and (optionally) one-hot-ness of the word
// BREAK | all TGATEs held off for one cycle before the new word lands
// APPLY | new select driven, commit_done pulsing; return to IDLE
module mux_cfg_chain_writer #(
  parameter int NUM_MEM      = 4,
  parameter bit ONEHOT_CHECK = 1'b1
) (
  input  logic                   prog_clk,
  input  logic                   pReset,
  mux_cfg_chain_writer_if.slave  bus
);

  localparam int             CW   = $clog2(NUM_MEM + 1);
  localparam logic [CW-1:0]  FULL = CW'(NUM_MEM);

  typedef enum logic [1:0] {IDLE, CHECK, BREAK, APPLY} state_e;

  state_e              state_q;
  logic [0:NUM_MEM-1]  shift_q;
  logic [0:NUM_MEM-1]  shift_d;
  logic [0:NUM_MEM-1]  mem_q;
  logic [0:NUM_MEM-1]  mem_inv_q;
  logic [CW-1:0]       bit_cnt_q;
  logic                tail_q;
  logic                tail_valid_q;
  logic                commit_done_q;
  logic                cfg_error_q;
  logic                head_ready;
  logic                shift_en;
  logic                word_bad;

  function automatic logic multi_hot(input logic [0:NUM_MEM-1] w);
    int n;
    n = 0;
    for (int i = 0; i < NUM_MEM; i++) n += int'(w[i]);
    return (n > 1);
  endfunction

  // A commit in IDLE wins over a shift presented in the same cycle.
  assign head_ready = (state_q == IDLE) && !bus.commit;
  assign shift_en   = head_ready && bus.ccff_head_valid;
  assign shift_d    = {bus.ccff_head, shift_q[0:NUM_MEM-2]};
  assign word_bad   = (bit_cnt_q < FULL) || (ONEHOT_CHECK && multi_hot(shift_q));

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      mem_q         <= '0;
      mem_inv_q     <= '1;
      tail_q        <= 1'b0;
      tail_valid_q  <= 1'b0;
      commit_done_q <= 1'b0;
      cfg_error_q   <= 1'b0;
    end else begin
      tail_valid_q <= shift_en;
      if (shift_en) begin
        shift_q <= shift_d;
        tail_q  <= shift_q[NUM_MEM-1];
        if (bit_cnt_q < FULL) bit_cnt_q <= bit_cnt_q + CW'(1);
      end

      case (state_q)
        IDLE: begin
          if (bus.commit) state_q <= CHECK;
        end
        CHECK: begin
          if (word_bad) begin
            cfg_error_q <= 1'b1;
            bit_cnt_q   <= '0;
            state_q     <= IDLE;
          end else begin
            mem_q     <= '0;
            mem_inv_q <= '1;
            state_q   <= BREAK;
          end
        end
        BREAK: begin
          mem_q         <= shift_q;
          mem_inv_q     <= ~shift_q;
          commit_done_q <= 1'b1;
          bit_cnt_q     <= '0;
          state_q       <= APPLY;
        end
        APPLY: begin
          commit_done_q <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ccff_head_ready = head_ready;
  assign bus.ccff_tail       = tail_q;
  assign bus.ccff_tail_valid = tail_valid_q;
  assign bus.commit_done     = commit_done_q;
  assign bus.cfg_error       = cfg_error_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.mem             = mem_q;
  assign bus.mem_inv         = mem_inv_q;

endmodule

// File: tb/tb_mux_cfg_chain_writer.sv
// Directed bench: two writers (one-hot check on/off) share the same stimulus.
// Words are written as [0:3] literals, so 4'b0001 means mem[3]=1.
module tb_mux_cfg_chain_writer;

  logic prog_clk = 1'b0;
  logic pReset;
  logic head;
  logic valid;
  logic commit;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] casc_bits;
  logic [7:0] casc_tail;

  mux_cfg_chain_writer_if #(.NUM_MEM(4)) b1 ();
  mux_cfg_chain_writer_if #(.NUM_MEM(4)) b0 ();

  assign b1.ccff_head       = head;
  assign b1.ccff_head_valid = valid;
  assign b1.commit          = commit;
  assign b0.ccff_head       = head;
  assign b0.ccff_head_valid = valid;
  assign b0.commit          = commit;

  mux_cfg_chain_writer #(.NUM_MEM(4), .ONEHOT_CHECK(1'b1)) dut1 (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (b1)
  );

  mux_cfg_chain_writer #(.NUM_MEM(4), .ONEHOT_CHECK(1'b0)) dut0 (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (b0)
  );

  always #5 prog_clk = ~prog_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the complementary-select invariant on both writers.
  task automatic tick();
    @(negedge prog_clk);
    if (pReset) begin
      chk4("inv1", b1.mem, ~b1.mem_inv);
      chk4("inv0", b0.mem, ~b0.mem_inv);
    end
  endtask

  // Push bits[n-1] first down to bits[0] last.
  task automatic shift_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      head  = bits[i];
      valid = 1'b1;
      tick();
    end
    valid = 1'b0;
    head  = 1'b0;
  endtask

  task automatic commit_ok(input string tag, input logic [3:0] old_w, input logic [3:0] new_w);
    commit = 1'b1;
    #1;
    chk1({tag, "_ready"}, b1.ccff_head_ready, 1'b0);
    tick();
    commit = 1'b0;
    chk1({tag, "_busy_e0"}, b1.busy, 1'b1);
    chk4({tag, "_mem_e0"}, b1.mem, old_w);
    tick();
    chk4({tag, "_mem_gap"}, b1.mem, 4'b0000);
    chk4({tag, "_inv_gap"}, b1.mem_inv, 4'b1111);
    chk1({tag, "_done_e1"}, b1.commit_done, 1'b0);
    tick();
    chk4({tag, "_mem_e2"}, b1.mem, new_w);
    chk4({tag, "_inv_e2"}, b1.mem_inv, ~new_w);
    chk1({tag, "_done_e2"}, b1.commit_done, 1'b1);
    chk1({tag, "_busy_e2"}, b1.busy, 1'b1);
    tick();
    chk1({tag, "_done_e3"}, b1.commit_done, 1'b0);
    chk1({tag, "_busy_e3"}, b1.busy, 1'b0);
  endtask

  initial begin
    pReset = 1'b0;
    head   = 1'b0;
    valid  = 1'b0;
    commit = 1'b0;
    tick();
    tick();
    chk4("rst_mem", b1.mem, 4'b0000);
    chk4("rst_inv", b1.mem_inv, 4'b1111);
    chk1("rst_ready", b1.ccff_head_ready, 1'b1);
    chk1("rst_busy", b1.busy, 1'b0);
    chk1("rst_err", b1.cfg_error, 1'b0);
    chk1("rst_tvalid", b1.ccff_tail_valid, 1'b0);
    chk1("rst_tail", b1.ccff_tail, 1'b0);
    chk1("rst_done", b1.commit_done, 1'b0);
    pReset = 1'b1;
    tick();

    // Cascading: 1,0,1,1,0,0,1,0 in, tail shows 0,0,0,0,1,0,1,1.
    casc_bits = 8'b1011_0010;
    casc_tail = 8'b0000_1011;
    for (int i = 7; i >= 0; i--) begin
      head  = casc_bits[i];
      valid = 1'b1;
      tick();
      chk1("casc_tvalid", b1.ccff_tail_valid, 1'b1);
      chk1("casc_tail", b1.ccff_tail, casc_tail[i]);
    end
    valid = 1'b0;
    tick();
    chk1("casc_tvalid_end", b1.ccff_tail_valid, 1'b0);
    chk4("casc_mem_untouched", b1.mem, 4'b0000);

    // One-hot load: first shifted bit lands in mem[3].
    shift_bits(8'b1000, 4);
    commit_ok("onehot", 4'b0000, 4'b0001);

    // Priority: commit and head_valid together; no shift, commit proceeds.
    shift_bits(8'b0100, 4);
    head   = 1'b1;
    valid  = 1'b1;
    commit = 1'b1;
    #1;
    chk1("prio_ready", b1.ccff_head_ready, 1'b0);
    tick();
    commit = 1'b0;
    chk1("prio_busy", b1.busy, 1'b1);
    chk1("prio_ready_busy", b1.ccff_head_ready, 1'b0);
    chk1("prio_noshift", b1.ccff_tail_valid, 1'b0);
    tick();
    chk4("prio_mem_gap", b1.mem, 4'b0000);
    chk1("prio_ready_check", b1.ccff_head_ready, 1'b0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk4("prio_mem", b1.mem, 4'b0010);
    chk4("prio_inv", b1.mem_inv, 4'b1101);
    chk1("prio_done", b1.commit_done, 1'b1);
    chk1("prio_noshift2", b1.ccff_tail_valid, 1'b0);
    tick();
    valid = 1'b0;
    head  = 1'b0;
    chk1("prio_idle", b1.busy, 1'b0);
    tick();
    chk1("busy_commit_not_queued", b1.busy, 1'b0);
    chk4("prio_mem_hold", b1.mem, 4'b0010);

    // Two-hot word: rejected with the check on, applied with it off.
    shift_bits(8'b1100, 4);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk1("twohot_busy1", b1.busy, 1'b1);
    chk1("twohot_busy0", b0.busy, 1'b1);
    tick();
    chk1("twohot_err1", b1.cfg_error, 1'b1);
    chk1("twohot_idle1", b1.busy, 1'b0);
    chk4("twohot_mem1_kept", b1.mem, 4'b0010);
    chk1("twohot_nodone1", b1.commit_done, 1'b0);
    chk4("twohot_gap0", b0.mem, 4'b0000);
    chk1("twohot_err0", b0.cfg_error, 1'b0);
    tick();
    chk1("twohot_nodone1b", b1.commit_done, 1'b0);
    chk4("twohot_mem1_kept2", b1.mem, 4'b0010);
    chk4("twohot_mem0", b0.mem, 4'b0011);
    chk4("twohot_inv0", b0.mem_inv, 4'b1100);
    chk1("twohot_done0", b0.commit_done, 1'b1);
    tick();
    chk1("twohot_done0_end", b0.commit_done, 1'b0);
    chk1("twohot_idle0", b0.busy, 1'b0);

    // Short load: 3 bits only, rejected by both writers.
    shift_bits(8'b100, 3);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    chk1("short_err1", b1.cfg_error, 1'b1);
    chk1("short_err0", b0.cfg_error, 1'b1);
    chk1("short_idle1", b1.busy, 1'b0);
    chk1("short_idle0", b0.busy, 1'b0);
    chk4("short_mem1", b1.mem, 4'b0010);
    chk4("short_mem0", b0.mem, 4'b0011);
    tick();
    chk1("short_nodone1", b1.commit_done, 1'b0);
    chk1("short_nodone0", b0.commit_done, 1'b0);

    // Full reload after error still applies; error stays sticky.
    shift_bits(8'b0001, 4);
    commit_ok("reload", 4'b0010, 4'b1000);
    chk4("reload_mem0", b0.mem, 4'b1000);
    chk1("reload_err1", b1.cfg_error, 1'b1);
    chk1("reload_err0", b0.cfg_error, 1'b1);

    // Zero word is legal and turns every TGATE off.
    shift_bits(8'b0000, 4);
    commit_ok("zero", 4'b1000, 4'b0000);

    // Reset mid-stream clears the tail pulse and the sticky error.
    head  = 1'b1;
    valid = 1'b1;
    tick();
    chk1("mid_tvalid", b1.ccff_tail_valid, 1'b1);
    pReset = 1'b0;
    #1;
    chk1("mid_rst_tvalid", b1.ccff_tail_valid, 1'b0);
    chk1("mid_rst_err", b1.cfg_error, 1'b0);
    chk1("mid_rst_ready", b1.ccff_head_ready, 1'b1);
    chk4("mid_rst_inv", b1.mem_inv, 4'b1111);
    valid = 1'b0;
    head  = 1'b0;
    tick();
    pReset = 1'b1;
    tick();

    // Abort during BREAK: reset wins immediately, nothing applied afterwards.
    shift_bits(8'b0100, 4);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    chk1("abort_in_break", b1.busy, 1'b1);
    pReset = 1'b0;
    #1;
    chk4("abort_mem", b1.mem, 4'b0000);
    chk4("abort_inv", b1.mem_inv, 4'b1111);
    chk1("abort_busy", b1.busy, 1'b0);
    chk1("abort_done", b1.commit_done, 1'b0);
    chk1("abort_ready", b1.ccff_head_ready, 1'b1);
    tick();
    pReset = 1'b1;
    tick();
    chk1("abort_stay_idle", b1.busy, 1'b0);
    chk4("abort_no_apply", b1.mem, 4'b0000);
    chk1("abort_no_done", b1.commit_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_cfg_chain_writer.md
Name: mux_cfg_chain_writer

Overview:
- Configuration-chain writer segment that produces the mem/mem_inv select pairs consumed by the TGATE-based routing and LUT multiplexer primitives.
- Accepts configuration bits serially from the upstream chain through a valid/ready handshake and forwards displaced bits downstream for cascading.
- On a commit request, checks the loaded select word, then applies it break-before-make, so no two TGATEs on a shared output ever conduct together.

Parameters:
- NUM_MEM, 4, number of mem/mem_inv pairs driven (one per TGATE on the mux output); legal range 2..16.
- ONEHOT_CHECK, 1, when 1, a commit whose word has more than one bit set is rejected; when 0, any word is applied.

Ports:
- prog_clk  input  1  configuration clock; the only clock.
- pReset  input  1  asynchronous, active-low reset.
- ccff_head  input  1  serial configuration bit from upstream.
- ccff_head_valid  input  1  ccff_head holds a bit to shift.
- ccff_head_ready  output  1  writer accepts a bit this cycle.
- ccff_tail  output  1  bit displaced from the chain, for the next segment.
- ccff_tail_valid  output  1  ccff_tail is valid, one-cycle pulse.
- commit  input  1  request to apply the shifted word to mem/mem_inv.
- commit_done  output  1  one-cycle pulse on successful apply.
- cfg_error  output  1  sticky flag for a rejected commit.
- busy  output  1  high whenever the state is not IDLE.
- mem  output  [0:NUM_MEM-1]  TGATE S controls.
- mem_inv  output  [0:NUM_MEM-1]  TGATE SI controls, always ~mem except during reset.

Behaviour:
- Reset (pReset=0, asynchronous) sets:
  - shift_reg=0, bit_cnt=0, state=IDLE
  - mem=all 0, mem_inv=all 1 (all TGATEs off)
  - ccff_tail=0, ccff_tail_valid=0, commit_done=0, cfg_error=0
  - Reset mid-commit abandons the commit immediately, with the same values.
- ccff_head_ready = (state==IDLE) && !commit. This is combinational; a commit in IDLE takes priority over a shift in the same cycle.
- Shift (head_valid && head_ready at a rising edge):
  - shift_reg[0]<=ccff_head; shift_reg[i]<=shift_reg[i-1].
  - ccff_tail<=old shift_reg[NUM_MEM-1], with ccff_tail_valid=1 for exactly the next cycle.
  - bit_cnt saturates at NUM_MEM.
  - The first of NUM_MEM shifted bits ends in shift_reg[NUM_MEM-1].
- Shifting never alters mem/mem_inv.
- FSM states: IDLE, CHECK, BREAK, APPLY.
  - IDLE -> CHECK when commit=1 (edge E0).
  - CHECK (edge E1):
    - If bit_cnt<NUM_MEM, or (ONEHOT_CHECK && popcount(shift_reg)>1): cfg_error<=1, bit_cnt<=0, state->IDLE, mem unchanged, no commit_done.
    - Otherwise: mem<=0, mem_inv<=all 1, state->BREAK.
  - BREAK (edge E2): mem<=shift_reg, mem_inv<=~shift_reg, commit_done<=1, bit_cnt<=0, state->APPLY.
  - APPLY (edge E3): commit_done<=0, state->IDLE.
- Latency: the new select is visible after E2, and the all-off gap lasts exactly one cycle (E1..E2).
- A zero word (popcount 0) is legal and leaves all TGATEs off.
- shift_reg is retained after a commit; re-committing requires a fresh NUM_MEM-bit load.
- cfg_error is cleared only by reset. A later successful commit still proceeds and pulses commit_done.
- commit asserted while busy is ignored; it is not queued.
- ccff_head_valid while busy is not accepted, and the upstream must hold the bit.
- Invariant (assertion): outside reset, mem[i]==~mem_inv[i] for all i, at every edge.

Test Plan:
- Reset check: assert pReset=0 mid-stream -> mem=4'b0000, mem_inv=4'b1111, ready=1, busy=0, cfg_error=0, tail_valid=0.
- One-hot load: NUM_MEM=4, shift 1,0,0,0, then commit -> E1 mem=0000/mem_inv=1111; E2 mem[3]=1, others 0, mem_inv[3]=0; commit_done high for one cycle; busy 3 cycles.
- Two-hot rejection: shift 1,1,0,0 with ONEHOT_CHECK=1, then commit -> cfg_error=1 at E1, mem keeps the prior value, no commit_done. Repeat with ONEHOT_CHECK=0 -> applied.
- Short load: shift only 3 bits, then commit -> cfg_error=1 and mem unchanged. Then shift 4 bits and commit -> applied, with cfg_error still 1.
- Cascading: shift 8 bits 1,0,1,1,0,0,1,0 -> tail_valid pulses 8 times; the tail sequence is 0,0,0,0,1,0,1,1.
- Priority and abort: head_valid=1 and commit=1 in the same IDLE cycle -> no shift, commit proceeds, head_ready=0 while busy. Assert pReset=0 in BREAK -> all TGATEs off, state IDLE.
